vedic_seq_mul_8: RTL and testbench



---
 rtl/vedic_seq_mul_8.sv | 126 ++++++++++++
 tb/tb_vedic_seq_mul_8.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vedic_seq_mul_8.sv
// Sequential 8x8 unsigned multiplier. One shared 4x4 Vedic core processes
// one nibble pair per cycle over four cycles, with valid/ready on both sides.

module vedic_2_x_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic w_x, w_y, w_hi, w_c;

  assign w_x  = a[1] & b[0];
  assign w_y  = a[0] & b[1];
  assign w_hi = a[1] & b[1];
  assign w_c  = w_x & w_y;

  assign p[0] = a[0] & b[0];
  assign p[1] = w_x ^ w_y;
  assign p[2] = w_hi ^ w_c;
  assign p[3] = w_hi & w_c;
endmodule

module vedic_4_x_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] w_q0, w_q1, w_q2, w_q3;

  vedic_2_x_2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(w_q0));
  vedic_2_x_2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(w_q1));
  vedic_2_x_2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(w_q2));
  vedic_2_x_2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(w_q3));

  // {hh,ll} already places the outer products; the cross terms sit at bit 2.
  assign p = {w_q3, w_q0} + {2'b00, w_q1, 2'b00} + {2'b00, w_q2, 2'b00};
endmodule

module vedic_seq_mul_8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_a, r_b;
  logic [15:0] r_acc;
  logic [1:0]  r_step;
  logic        r_out_valid;
  logic [15:0] r_p;

  logic [3:0]  w_na, w_nb;
  logic [7:0]  w_pp;
  logic [15:0] w_pp_sh;
  logic [15:0] w_sum;

  // step[0] picks the high nibble of a, step[1] the high nibble of b.
  assign w_na = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_nb = r_step[1] ? r_b[7:4] : r_b[3:0];

  vedic_4_x_4 u_core (.a(w_na), .b(w_nb), .p(w_pp));

  always_comb begin
    w_pp_sh = '0;
    case (r_step)
      2'd0:    w_pp_sh = {8'h00, w_pp};
      2'd1,
      2'd2:    w_pp_sh = {4'h0, w_pp, 4'h0};
      default: w_pp_sh = {w_pp, 8'h00};
    endcase
  end

  assign w_sum = r_acc + w_pp_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_step      <= '0;
      r_out_valid <= 1'b0;
      r_p         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_step  <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc  <= w_sum;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_p         <= w_sum;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign p         = r_p;
endmodule

// File: tb/tb_vedic_seq_mul_8.sv
// Bench for vedic_seq_mul_8: directed vector table, backpressure and reset
// corner cases, and a randomized sweep checked through a result scoreboard.

module tb_vedic_seq_mul_8;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  vedic_seq_mul_8 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] vp;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_acc    = 0;
  int unsigned n_out    = 0;
  logic [15:0] sb[$];
  bit          rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, want 0x%04h", nm, act, exp);
  endtask

  // Handshakes complete at the next posedge; inputs are stable at negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(16'(a) * 16'(b));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) chk("sb_unexpected_out", {15'd0, out_valid}, 16'd0);
        else chk("sb_p", p, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] va, input logic [7:0] vb);
    bit ok;
    ok = 1'b0;
    a = va;
    b = vb;
    in_valid = 1'b1;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("accept", {15'd0, ok}, 16'd1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  vec_t vecs[4];
  int   lat;

  initial begin
    vecs[0] = '{8'h12, 8'h34, 16'h03A8};
    vecs[1] = '{8'h00, 8'hAB, 16'h0000};
    vecs[2] = '{8'h01, 8'h80, 16'h0080};
    vecs[3] = '{8'h80, 8'hFF, 16'h7F80};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_p", p, 16'h0000);
    rst_n = 1'b1;
    tick();

    // 0xFF*0xFF with cycle-by-cycle latency and in_ready checks.
    send(8'hFF, 8'hFF);
    for (int i = 1; i <= 3; i++) begin
      chk("ff_in_ready_calc", {15'd0, in_ready}, 16'd0);
      chk("ff_out_valid_early", {15'd0, out_valid}, 16'd0);
      tick();
    end
    chk("ff_busy", {15'd0, busy}, 16'd1);
    tick();
    chk("ff_out_valid", {15'd0, out_valid}, 16'd1);
    chk("ff_p", p, 16'hFE01);
    chk("ff_in_ready_done", {15'd0, in_ready}, 16'd0);
    tick();
    chk("ff_in_ready_after", {15'd0, in_ready}, 16'd1);
    chk("ff_out_valid_after", {15'd0, out_valid}, 16'd0);

    foreach (vecs[i]) begin
      send(vecs[i].va, vecs[i].vb);
      wait_out(lat);
      chk("vec_latency", 16'(lat), 16'd4);
      chk("vec_p", p, vecs[i].vp);
      tick();
    end

    // Backpressure: result held while a new pair waits on in_valid.
    out_ready = 1'b0;
    send(8'h9C, 8'h27);
    wait_out(lat);
    chk("bp_latency", 16'(lat), 16'd4);
    a = 8'h55; b = 8'h02; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_p", p, 16'h17C4);
      chk("bp_out_valid", {15'd0, out_valid}, 16'd1);
      chk("bp_busy", {15'd0, busy}, 16'd1);
      chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
    end
    out_ready = 1'b1;
    send(8'h55, 8'h02);
    wait_out(lat);
    chk("bp_next_p", p, 16'h00AA);
    tick();

    // Reset two compute cycles into a product.
    send(8'hF0, 8'h0F);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("mrst_p", p, 16'h0000);
    chk("mrst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("mrst_busy", {15'd0, busy}, 16'd0);
    sb.delete();
    n_acc = n_out;
    tick();
    rst_n = 1'b1;
    send(8'h03, 8'h05);
    wait_out(lat);
    chk("mrst_latency", 16'(lat), 16'd4);
    chk("mrst_next_p", p, 16'h000F);
    tick();

    // Randomized sweep with idle gaps and consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i < 4) begin
        ra = (i[0]) ? 8'hFF : 8'h00;
        rb = (i[1]) ? 8'hFF : 8'h00;
      end
      repeat ($urandom_range(0, 2)) tick();
      send(ra, rb);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && (sb.size() != 0 || busy); c++) tick();
    chk("drain_empty", 16'(sb.size()), 16'd0);
    chk("acc_vs_out", 16'(n_out), 16'(n_acc));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
